// File: rtl/serial_adder_unit.sv
// Multi-cycle bit-serial adder: DIGIT bits per clock through a ripple of half-adder-pair slices.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for a-b via inverted-B / forced carry-in.
module serial_adder_unit #(
   parameter int WIDTH = 4,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_sub;
   logic             w_accept;
   logic             w_last;
   logic [DIGIT:0]   w_c;
   logic [DIGIT-1:0] w_s;
   logic [DIGIT-1:0] w_h1s;
   logic [DIGIT-1:0] w_h1c;
   logic [DIGIT-1:0] w_h2c;
   logic [WIDTH-1:0] w_a_next;

`ifdef SERIAL_ADD_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

   // Full-adder slice per digit bit: two half adders plus an OR for the carry.
   assign w_c[0] = r_carry;
   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      assign w_h1s[gi]  = r_a[gi] ^ r_b[gi];
      assign w_h1c[gi]  = r_a[gi] & r_b[gi];
      assign w_s[gi]    = w_h1s[gi] ^ w_c[gi];
      assign w_h2c[gi]  = w_h1s[gi] & w_c[gi];
      assign w_c[gi+1]  = w_h1c[gi] | w_h2c[gi];
   end

   // Result digits refill the vacated MSBs of the A register, so it ends up holding the sum.
   assign w_a_next = (r_a >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_a     <= a;
         r_b     <= w_sub ? ~b : b;
         r_carry <= w_sub ? 1'b1 : cin;
      end else if (r_state == S_RUN) begin
         r_cnt   <= r_cnt + CW'(1);
         r_a     <= w_a_next;
         r_b     <= r_b >> DIGIT;
         r_carry <= w_c[DIGIT];
         if (w_last) begin
            r_sum  <= w_a_next;
            r_cout <= w_c[DIGIT];
            r_ovf  <= w_c[DIGIT-1] ^ w_c[DIGIT];
         end
      end
   end

   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule
